// File: rtl/prn_code_generator.sv
// prn_code_generator: GPS L1C Weil-code chip streamer for PRN 1..8 (data/pilot); define PRN_REPEAT_EN for gapless repeat while start is held
module prn_code_generator (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  prn_id,
    input  logic        pd,
    output logic [13:0] addr,
    output logic        out_valid,
    output logic        prn_bit
);
    localparam int N_LEG = 10223;
    localparam int N_CODE = 10230;
    localparam logic [6:0] EXP_SEQ = 7'b0110100;
    localparam logic [13:0] W_TAB [0:15] = '{
        14'd5111, 14'd5109, 14'd5108, 14'd5106, 14'd5103, 14'd5101, 14'd5100, 14'd5098,
        14'd5097, 14'd5110, 14'd5079, 14'd4403, 14'd4121, 14'd5043, 14'd5042, 14'd5104
    };
    localparam logic [13:0] P_TAB [0:15] = '{
        14'd412, 14'd161, 14'd1, 14'd303, 14'd207, 14'd4971, 14'd4496, 14'd5,
        14'd181, 14'd359, 14'd72, 14'd1110, 14'd1480, 14'd5034, 14'd4622, 14'd1
    };
    typedef enum logic [2:0] {IDLE, CLEAR, BUILD, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [13:0] cnt_q, cnt_d, r_q, r_d, addr_q, addr_d, s1_addr_q, s1_addr_d;
    logic [2:0] prn_q, prn_d;
    logic ready_q, ready_d, pd_q, pd_d;
    logic s1_valid_q, s1_valid_d, s1_exp_q, s1_exp_d, s1_ebit_q, s1_ebit_d;
    logic out_valid_q, out_valid_d, prn_bit_q, prn_bit_d;
    logic l0_q, l1_q;
    logic [13:0] w, p, k, kw, rd_b, wa;
    logic [14:0] r_sum, r_sub1, r_sub2;
    logic [2:0] ej;
    logic we, wd, last_t;
    logic leg_mem [0:N_LEG-1];
    always_comb begin
        w = W_TAB[{pd_q, prn_q}];
        p = P_TAB[{pd_q, prn_q}];
        k = (cnt_q >= p + 14'd6) ? cnt_q - 14'd7 : cnt_q;
        kw = k + w;
        rd_b = (kw >= 14'(N_LEG)) ? kw - 14'(N_LEG) : kw;
        ej = 3'(cnt_q + 14'd1 - p);
        // (x+1)^2 = x^2 + 2x + 1, folded back below N without a multiplier
        r_sum = {1'b0, r_q} + {cnt_q, 1'b1};
        r_sub1 = (r_sum >= 15'(N_LEG)) ? r_sum - 15'(N_LEG) : r_sum;
        r_sub2 = (r_sub1 >= 15'(N_LEG)) ? r_sub1 - 15'(N_LEG) : r_sub1;
        last_t = cnt_q == 14'(N_CODE - 1);
        state_d = state_q;
        cnt_d = cnt_q;
        r_d = r_q;
        ready_d = ready_q;
        prn_d = prn_q;
        pd_d = pd_q;
        we = 1'b0;
        wa = cnt_q;
        wd = 1'b0;
        s1_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    prn_d = prn_id;
                    pd_d = pd;
                    cnt_d = '0;
                    state_d = ready_q ? RUN : CLEAR;
                end
            end
            CLEAR: begin
                we = 1'b1;
                cnt_d = cnt_q + 14'd1;
                if (cnt_q == 14'(N_LEG - 1)) begin
                    state_d = BUILD;
                    cnt_d = 14'd1;
                    r_d = 14'd1;
                end
            end
            BUILD: begin
                we = 1'b1;
                wa = r_q;
                wd = 1'b1;
                cnt_d = cnt_q + 14'd1;
                r_d = r_sub2[13:0];
                if (cnt_q == 14'd5111) begin
                    state_d = RUN;
                    cnt_d = '0;
                    ready_d = 1'b1;
                end
            end
            RUN: begin
                s1_valid_d = 1'b1;
                cnt_d = cnt_q + 14'd1;
                if (last_t) begin
`ifdef PRN_REPEAT_EN
                    if (start) begin
                        cnt_d = '0;
                        prn_d = prn_id;
                        pd_d = pd;
                    end else begin
                        state_d = DONE;
                    end
`else
                    state_d = DONE;
`endif
                end
            end
            DONE: state_d = start ? DONE : IDLE;
            default: state_d = IDLE;
        endcase
        s1_addr_d = cnt_q;
        s1_exp_d = (cnt_q + 14'd1 >= p) && (cnt_q < p + 14'd6);
        s1_ebit_d = EXP_SEQ[3'd6 - ej];
        out_valid_d = s1_valid_q;
        addr_d = s1_valid_q ? s1_addr_q : addr_q;
        prn_bit_d = s1_valid_q && (s1_exp_q ? s1_ebit_q : l0_q ^ l1_q);
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            r_q <= '0;
            ready_q <= 1'b0;
            prn_q <= '0;
            pd_q <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_addr_q <= '0;
            s1_exp_q <= 1'b0;
            s1_ebit_q <= 1'b0;
            out_valid_q <= 1'b0;
            addr_q <= '0;
            prn_bit_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            r_q <= r_d;
            ready_q <= ready_d;
            prn_q <= prn_d;
            pd_q <= pd_d;
            s1_valid_q <= s1_valid_d;
            s1_addr_q <= s1_addr_d;
            s1_exp_q <= s1_exp_d;
            s1_ebit_q <= s1_ebit_d;
            out_valid_q <= out_valid_d;
            addr_q <= addr_d;
            prn_bit_q <= prn_bit_d;
        end
    end
    always_ff @(posedge clk) begin
        if (we) leg_mem[wa] <= wd;
        l0_q <= leg_mem[k];
        l1_q <= leg_mem[rd_b];
    end
    assign addr = addr_q;
    assign out_valid = out_valid_q;
    assign prn_bit = prn_bit_q;
endmodule

// File: tb/tb_prn_code_generator.sv
// tb_prn_code_generator: directed runs of the L1C generator compared against a Legendre/Weil software model
`timescale 1ns/1ps
module tb_prn_code_generator;
    localparam int N = 10223;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic pd = 1'b0;
    logic [2:0] prn_id = 3'd0;
    logic [13:0] addr;
    logic out_valid, prn_bit;
    int checks = 0;
    int errors = 0;
    bit leg [0:N-1];
    typedef struct {int prn; int pd; int w; int p; int lat; int last;} vec_t;
    prn_code_generator dut (
        .clk(clk), .rst(rst), .start(start), .prn_id(prn_id), .pd(pd),
        .addr(addr), .out_valid(out_valid), .prn_bit(prn_bit)
    );
    always #5 clk = ~clk;
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    function automatic bit weil(input int k, input int w);
        return leg[k] ^ leg[(k + w) % N];
    endfunction
    function automatic bit chip(input int t, input int w, input int p);
        bit [6:0] e;
        e = 7'b0110100;
        if (t < p - 1) return weil(t, w);
        if (t <= p + 5) return e[6 - (t - p + 1)];
        return weil(t - 7, w);
    endfunction
    initial begin
        vec_t v [6];
        int lat, n, bad_bit, bad_addr, exp_bits, first_bad;
        string tag;
        for (int x = 1; x <= 5111; x++) leg[(x * x) % N] = 1'b1;
        v[0] = '{2, 0, 5108, 1, 15336, 10229};
        v[1] = '{4, 0, 5103, 207, 2, 10229};
        v[2] = '{7, 1, 5104, 1, 2, 10229};
        v[3] = '{5, 1, 5043, 5034, 2, 10229};
        v[4] = '{6, 1, 5042, 4622, 2, 5000};
        v[5] = '{0, 1, 5097, 181, 15336, 200};
        start = 1'b1;
        prn_id = 3'd2;
        repeat (2) tick;
        check("reset out_valid", out_valid, 0);
        check("reset addr", addr, 0);
        check("reset prn_bit", prn_bit, 0);
        start = 1'b0;
        rst = 1'b1;
        repeat (4) tick;
        check("idle out_valid after reset", out_valid, 0);
        for (int i = 0; i < 6; i++) begin
            tag = $sformatf("run%0d prn_id=%0d pd=%0d", i, v[i].prn, v[i].pd);
            prn_id = 3'(v[i].prn);
            pd = 1'(v[i].pd);
            start = 1'b1;
            tick;
            prn_id = ~prn_id;
            pd = ~pd;
            lat = 0;
            while (!out_valid && lat < 20000) begin
                tick;
                lat++;
            end
            check({tag, " latency"}, lat, v[i].lat);
            n = 0;
            bad_bit = 0;
            bad_addr = 0;
            exp_bits = 0;
            first_bad = -1;
            while (out_valid && n <= v[i].last) begin
                if (addr != 14'(n)) bad_addr++;
                if (prn_bit != chip(n, v[i].w, v[i].p)) begin
                    bad_bit++;
                    if (first_bad < 0) first_bad = n;
                end
                if (n >= v[i].p - 1 && n <= v[i].p + 5) exp_bits = (exp_bits << 1) | int'(prn_bit);
                n++;
                if (n <= v[i].last) tick;
            end
            check({tag, " valid chips"}, n, v[i].last + 1);
            check({tag, " addr sequence errors"}, bad_addr, 0);
            check($sformatf("%s chip errors (first at %0d)", tag, first_bad), bad_bit, 0);
            check({tag, " expansion chips"}, exp_bits, 7'b0110100);
            if (v[i].last == 10229) begin
                tick;
                check({tag, " out_valid after last chip"}, out_valid, 0);
                check({tag, " addr held in DONE"}, addr, 10229);
                repeat (5) tick;
                check({tag, " no retrigger with start held"}, out_valid, 0);
                start = 1'b0;
                repeat (2) tick;
            end else begin
                start = 1'b0;
                rst = 1'b0;
                tick;
                check({tag, " mid-run reset out_valid"}, out_valid, 0);
                check({tag, " mid-run reset addr"}, addr, 0);
                rst = 1'b1;
                tick;
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
